alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters, e.g. port 0 = execute stage, port 1 = address/branch unit.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, operation codes and response slot states.
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 5;

    // Codes outside this set are passed to the ALU untouched and behave as ADD.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SADD = 5'd2,
        ALU_SSUB = 5'd3
    } alu_op_e;

    // One-deep response slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer,
// pointer moves to the slot after the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] win_idx;
    int            idx;

    // Find the first requester at or after the pointer, wrapping around.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_valid = 1'b1;
                win_idx   = idx[PW-1:0];
            end
        end
    end

    // Advance past the winner; an idle cycle leaves the pointer alone.
    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_valid) begin
            if (win_idx == PW'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = win_idx + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Each requester gets a one-deep registered response slot, so a granted
// operation's result appears on the following cycle.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = alu_pkg::XLEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*XLEN-1:0]   req_a,
    input  logic [NUM_REQ*XLEN-1:0]   req_b,
    input  logic [NUM_REQ*5-1:0]      req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*XLEN-1:0]   rsp_result,
    output logic [XLEN-1:0]           alu_operand_a,
    output logic [XLEN-1:0]           alu_operand_b,
    output logic [4:0]                alu_select_op,
    input  logic [XLEN-1:0]           alu_result_in,
    output logic [15:0]               grant_count
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [15:0]        grant_count_reg;

    genvar gi;

    // A requester competes only when its slot is empty or draining this
    // cycle; reset holds everyone out so nothing is granted while rst_n is low.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = rst_n & req_valid[gi] & (~rsp_valid[gi] | rsp_ready[gi]);
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (eligible),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    assign req_ready = gnt;

    // Route the winner's operands to the ALU; idle cycles present a zero ADD.
    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_select_op = ALU_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_operand_a = req_a[i*XLEN +: XLEN];
                alu_operand_b = req_b[i*XLEN +: XLEN];
                alu_select_op = req_op[i*5 +: 5];
            end
        end
    end

    // Per-requester response slot: occupancy FSM plus result register.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            slot_state_e     state_reg;
            slot_state_e     state_next;
            logic [XLEN-1:0] result_reg;

            // Slot occupancy register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= SLOT_EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Fill on grant; drain only when taken without a same-cycle refill.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    SLOT_EMPTY: begin
                        if (gnt[gi]) begin
                            state_next = SLOT_FULL;
                        end
                    end
                    SLOT_FULL: begin
                        if (!gnt[gi] && rsp_ready[gi]) begin
                            state_next = SLOT_EMPTY;
                        end
                    end
                    default: begin
                        state_next = SLOT_EMPTY;
                    end
                endcase
            end

            // Capture the ALU result on grant; otherwise hold it stable.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    result_reg <= '0;
                end else if (gnt[gi]) begin
                    result_reg <= alu_result_in;
                end
            end

            assign rsp_valid[gi]                 = (state_reg == SLOT_FULL);
            assign rsp_result[gi*XLEN +: XLEN]   = result_reg;
        end
    endgenerate

    // Free-running grant counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_count_reg <= '0;
        end else if (gnt_valid) begin
            grant_count_reg <= grant_count_reg + 16'd1;
        end
    end

    assign grant_count = grant_count_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: external ALU model, per-cycle reference model
// compare, and directed scenarios with literal expectations.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int X = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*X-1:0]  req_a = '0;
    logic [N*X-1:0]  req_b = '0;
    logic [N*5-1:0]  req_op = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [N*X-1:0]  rsp_result;
    logic [X-1:0]    alu_operand_a;
    logic [X-1:0]    alu_operand_b;
    logic [4:0]      alu_select_op;
    logic [X-1:0]    alu_result_in;
    logic [15:0]     grant_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr = 0;
    logic [N-1:0] m_valid = '0;
    logic [X-1:0] m_res [N];
    logic [15:0] m_cnt = '0;
    int          m_g = -1;

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_select_op (alu_select_op),
        .alu_result_in (alu_result_in),
        .grant_count   (grant_count)
    );

    always #5 clk = ~clk;

    function automatic logic [X-1:0] alu_f(input logic [X-1:0] a, input logic [X-1:0] b,
                                           input logic [4:0] op);
        logic [X-1:0] r;
        case (op)
            ALU_SUB:  r = a - b;
            ALU_SADD: r = X'($signed(a) + $signed(b));
            ALU_SSUB: r = X'($signed(a) - $signed(b));
            default:  r = a + b;
        endcase
        return r;
    endfunction

    // External ALU, combinational
    always_comb alu_result_in = alu_f(alu_operand_a, alu_operand_b, alu_select_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp,
                         input bit verbose);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end else if (verbose) begin
            $display("check %s ok: %h", name, act);
        end
    endtask

    function automatic bit m_elig(input int i);
        return req_valid[i] && (!m_valid[i] || rsp_ready[i]);
    endfunction

    // Model compare every cycle at the falling edge; model advances at the rising edge.
    initial begin
        m_res[0] = '0;
        m_res[1] = '0;
        forever begin
            logic [N-1:0] e_ready;
            logic [X-1:0] e_a, e_b;
            logic [4:0]   e_op;
            @(negedge clk);
            m_g = -1;
            if (rst_n) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && m_elig((m_ptr + k) % N)) m_g = (m_ptr + k) % N;
                end
            end
            e_ready = '0;
            e_a = '0;
            e_b = '0;
            e_op = 5'd0;
            if (m_g >= 0) begin
                e_ready = N'(1) << m_g;
                e_a  = req_a[m_g*X +: X];
                e_b  = req_b[m_g*X +: X];
                e_op = req_op[m_g*5 +: 5];
            end
            check("model_req_ready", 64'(req_ready), 64'(e_ready), 1'b0);
            check("model_alu_a", 64'(alu_operand_a), 64'(e_a), 1'b0);
            check("model_alu_b", 64'(alu_operand_b), 64'(e_b), 1'b0);
            check("model_alu_op", 64'(alu_select_op), 64'(e_op), 1'b0);
            check("model_rsp_valid", 64'(rsp_valid), 64'(m_valid), 1'b0);
            check("model_rsp_result", rsp_result, {m_res[1], m_res[0]}, 1'b0);
            check("model_grant_count", 64'(grant_count), 64'(m_cnt), 1'b0);
            @(posedge clk);
            if (!rst_n) begin
                m_ptr = 0;
                m_valid = '0;
                m_res[0] = '0;
                m_res[1] = '0;
                m_cnt = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_g == i) begin
                        m_valid[i] = 1'b1;
                        m_res[i] = alu_f(req_a[i*X +: X], req_b[i*X +: X], req_op[i*5 +: 5]);
                    end else if (rsp_ready[i]) begin
                        m_valid[i] = 1'b0;
                    end
                end
                if (m_g >= 0) begin
                    m_ptr = (m_g + 1) % N;
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [X-1:0] a, input logic [X-1:0] b,
                           input logic [4:0] op);
        req_a[p*X +: X] = a;
        req_b[p*X +: X] = b;
        req_op[p*5 +: 5] = op;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests asserted to show they are blocked
        rst_n = 1'b0;
        req_valid = 2'b11;
        set_req(0, 32'h11, 32'h22, ALU_SUB);
        set_req(1, 32'h33, 32'h44, ALU_ADD);
        tick();
        tick();
        at_neg();
        check("reset_req_ready", 64'(req_ready), 64'h0, 1'b1);
        check("reset_alu_a", 64'(alu_operand_a), 64'h0, 1'b1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0, 1'b1);
        check("reset_grant_count", 64'(grant_count), 64'h0, 1'b1);
        tick();
        rst_n = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;

        // Single op: 5 - 3
        set_req(0, 32'd5, 32'd3, ALU_SUB);
        req_valid = 2'b01;
        at_neg();
        check("single_req_ready", 64'(req_ready), 64'h1, 1'b1);
        check("single_alu_a", 64'(alu_operand_a), 64'd5, 1'b1);
        check("single_alu_op", 64'(alu_select_op), 64'd1, 1'b1);
        tick();
        req_valid = 2'b00;
        at_neg();
        check("single_rsp_valid0", 64'(rsp_valid[0]), 64'h1, 1'b1);
        check("single_result0", 64'(rsp_result[31:0]), 64'd2, 1'b1);
        tick();

        // Contention from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 32'd10, 32'd20, ALU_SUB);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check($sformatf("contend_grant%0d", c), 64'(req_ready),
                  (c % 2 == 0) ? 64'h1 : 64'h2, 1'b1);
            tick();
        end
        req_valid = 2'b00;
        at_neg();
        check("contend_grant_count", 64'(grant_count), 64'd4, 1'b1);
        check("contend_result0", 64'(rsp_result[31:0]), 64'd3, 1'b1);
        check("contend_result1", 64'(rsp_result[63:32]), 64'hFFFF_FFF6, 1'b1);
        tick();

        // Backpressure on port 1
        rsp_ready = 2'b01;
        set_req(1, 32'd7, 32'd1, ALU_ADD);
        req_valid = 2'b10;
        at_neg();
        check("bp_first_grant", 64'(req_ready), 64'h2, 1'b1);
        tick();
        set_req(1, 32'd9, 32'd9, ALU_ADD);
        at_neg();
        check("bp_blocked", 64'(req_ready), 64'h0, 1'b1);
        check("bp_hold_result", 64'(rsp_result[63:32]), 64'd8, 1'b1);
        tick();
        at_neg();
        check("bp_still_held", 64'(rsp_result[63:32]), 64'd8, 1'b1);
        check("bp_valid1", 64'(rsp_valid), 64'h2, 1'b1);
        tick();
        rsp_ready = 2'b11;
        at_neg();
        check("bp_refill_grant", 64'(req_ready), 64'h2, 1'b1);
        check("bp_drain_result", 64'(rsp_result[63:32]), 64'd8, 1'b1);
        tick();
        req_valid = 2'b00;
        at_neg();
        check("bp_second_result", 64'(rsp_result[63:32]), 64'd18, 1'b1);
        check("bp_second_valid", 64'(rsp_valid[1]), 64'h1, 1'b1);
        tick();

        // Signed and default ops, back to back on port 0
        rsp_ready = 2'b11;
        set_req(0, 32'hFFFF_FFFF, 32'd1, ALU_SADD);
        req_valid = 2'b01;
        at_neg();
        check("sop_grant", 64'(req_ready), 64'h1, 1'b1);
        tick();
        set_req(0, 32'hFFFF_FFFF, 32'd1, ALU_SSUB);
        at_neg();
        check("sop_sadd", 64'(rsp_result[31:0]), 64'h0, 1'b1);
        check("sop_b2b_grant", 64'(req_ready), 64'h1, 1'b1);
        tick();
        set_req(0, 32'hFFFF_FFFF, 32'd1, 5'h1F);
        at_neg();
        check("sop_ssub", 64'(rsp_result[31:0]), 64'hFFFF_FFFE, 1'b1);
        check("sop_op_passthru", 64'(alu_select_op), 64'h1F, 1'b1);
        tick();
        req_valid = 2'b00;
        at_neg();
        check("sop_default_add", 64'(rsp_result[31:0]), 64'h0, 1'b1);
        tick();

        // Reset mid-operation
        rsp_ready = 2'b00;
        set_req(0, 32'h50, 32'h5, ALU_ADD);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        at_neg();
        check("rmid_full", 64'(rsp_valid), 64'h1, 1'b1);
        check("rmid_result", 64'(rsp_result[31:0]), 64'h55, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        at_neg();
        check("rmid_valid_clear", 64'(rsp_valid), 64'h0, 1'b1);
        check("rmid_count_clear", 64'(grant_count), 64'h0, 1'b1);
        check("rmid_result_clear", rsp_result, 64'h0, 1'b1);
        tick();
        set_req(1, 32'd1, 32'd1, ALU_ADD);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        at_neg();
        check("rmid_first_port0", 64'(req_ready), 64'h1, 1'b1);
        tick();
        at_neg();
        check("rmid_then_port1", 64'(req_ready), 64'h2, 1'b1);
        tick();
        req_valid = 2'b00;
        tick();

        // Counter wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 32'd3, 32'd4, ALU_ADD);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        repeat (65535) tick();
        at_neg();
        check("wrap_count_ffff", 64'(grant_count), 64'hFFFF, 1'b1);
        tick();
        req_valid = 2'b00;
        at_neg();
        check("wrap_count_zero", 64'(grant_count), 64'h0, 1'b1);
        check("wrap_rsp_valid", 64'(rsp_valid), 64'h1, 1'b1);
        check("wrap_result", 64'(rsp_result[31:0]), 64'd7, 1'b1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
